// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Covers funct3 codes, FSM states, the latched command, and lane/misalign helpers.
package mem_lsu_pkg;

  localparam int LSU_DATA_W = 32;
  localparam int LSU_ADDR_W = 32;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } lsu_op_t;

  typedef struct packed {
    lsu_op_t                 op;
    logic [2:0]              opcode;
    logic [LSU_ADDR_W-3:0]   word_addr;
    logic [1:0]              byte_off;
    logic [3:0]              be;
    logic [LSU_DATA_W-1:0]   wdata;
  } lsu_cmd_t;

  // Unknown opcodes fall back to word access, so they check word alignment.
  function automatic logic lsu_misaligned(input logic is_load, input logic [2:0] opcode,
                                          input logic [1:0] off);
    logic fault;
    fault = |off;
    if (is_load) begin
      case (opcode)
        LSU_LB, LSU_LBU: fault = 1'b0;
        LSU_LH, LSU_LHU: fault = off[0];
        default:         fault = |off;
      endcase
    end else begin
      case (opcode)
        LSU_SB:  fault = 1'b0;
        LSU_SH:  fault = off[0];
        default: fault = |off;
      endcase
    end
    return fault;
  endfunction

  function automatic logic [3:0] lsu_byteenable(input logic is_load, input logic [2:0] opcode,
                                                input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (!is_load) begin
      case (opcode)
        LSU_SB:  be = 4'b0001 << off;
        LSU_SH:  be = 4'b0011 << off;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  function automatic logic [LSU_DATA_W-1:0] lsu_store_data(input logic [2:0] opcode,
                                                          input logic [LSU_DATA_W-1:0] wd);
    logic [LSU_DATA_W-1:0] d;
    case (opcode)
      LSU_SB:  d = {4{wd[7:0]}};
      LSU_SH:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Avalon-MM style data-memory bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/mem_lsu_load_align.sv
// Combinational load lane select and sign/zero extension of a 32-bit bus word.
module mem_lsu_load_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]            opcode_i,
  input  logic [1:0]            byte_off_i,
  input  logic [LSU_DATA_W-1:0] rdata_i,
  output logic [LSU_DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (byte_off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (opcode_i)
      LSU_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: data_o = {24'd0, byte_sel};
      LSU_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: misalign check, command latch, bus FSM and
// pipeline stall generation for a single outstanding data-memory transaction.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_mem_read,
  input  logic              lsu_mem_write,
  input  logic [2:0]        lsu_mem_opcode,
  input  logic [ADDR_W-1:0] lsu_address,
  input  logic [DATA_W-1:0] lsu_writedata,
  input  logic              lsu_flush,
  input  logic              lsu_hold,
  output logic              lsu_exception_load_addr_misaligned,
  output logic              lsu_exception_store_addr_misaligned,
  output logic              lsu_stall_req,
  output logic [DATA_W-1:0] lsu_readdata,
  output logic              lsu_readdata_valid,
  mem_lsu_if.master         bus
);

  lsu_state_t state_q, state_d;
  lsu_cmd_t   cmd_q, cmd_d;

  logic                  is_load;
  logic                  load_fault;
  logic                  store_fault;
  logic                  misaligned;
  logic                  accept;
  logic [LSU_DATA_W-1:0] aligned_data;

  // Read wins when both commands are raised, so it selects the checks used.
  assign is_load     = lsu_mem_read;
  assign load_fault  = lsu_misaligned(1'b1, lsu_mem_opcode, lsu_address[1:0]);
  assign store_fault = lsu_misaligned(1'b0, lsu_mem_opcode, lsu_address[1:0]);
  assign misaligned  = is_load ? load_fault : store_fault;

  assign lsu_exception_load_addr_misaligned  = lsu_mem_read  & load_fault  & ~lsu_flush;
  assign lsu_exception_store_addr_misaligned = lsu_mem_write & store_fault & ~lsu_flush;

  assign accept = (lsu_mem_read | lsu_mem_write) & ~misaligned & ~lsu_flush
                & ~lsu_hold & ~lsu_stall_req;

  always_comb begin
    cmd_d = cmd_q;
    if (accept) begin
      cmd_d.op        = is_load ? OP_LOAD : OP_STORE;
      cmd_d.opcode    = lsu_mem_opcode;
      cmd_d.word_addr = lsu_address[ADDR_W-1:2];
      cmd_d.byte_off  = lsu_address[1:0];
      cmd_d.be        = lsu_byteenable(is_load, lsu_mem_opcode, lsu_address[1:0]);
      cmd_d.wdata     = lsu_store_data(lsu_mem_opcode, lsu_writedata);
    end
  end

  // Stall only looks at state and slave signals, so accept never loops back on itself.
  always_comb begin
    state_d            = state_q;
    lsu_stall_req      = 1'b0;
    lsu_readdata_valid = 1'b0;
    bus.read           = 1'b0;
    bus.write          = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CMD;
      end
      CMD: begin
        bus.read  = (cmd_q.op == OP_LOAD);
        bus.write = (cmd_q.op == OP_STORE);
        if (bus.waitrequest) begin
          lsu_stall_req = 1'b1;
        end else if (cmd_q.op == OP_LOAD) begin
          lsu_stall_req = 1'b1;
          state_d       = RESP;
        end else begin
          state_d = accept ? CMD : IDLE;
        end
      end
      RESP: begin
        if (bus.readdatavalid) begin
          lsu_readdata_valid = 1'b1;
          state_d            = accept ? CMD : IDLE;
        end else begin
          lsu_stall_req = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  assign bus.address    = {cmd_q.word_addr, 2'b00};
  assign bus.writedata  = cmd_q.wdata;
  assign bus.byteenable = cmd_q.be;

  mem_lsu_load_align u_align (
    .opcode_i   (cmd_q.opcode),
    .byte_off_i (cmd_q.byte_off),
    .rdata_i    (bus.readdata),
    .data_o     (aligned_data)
  );

  assign lsu_readdata = lsu_readdata_valid ? aligned_data : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: stores, loads with wait/latency, misalign,
// flush, back-to-back stores and reset abandoning a load.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, flush, hold;
  logic [2:0]  opcode;
  logic [31:0] address, wdata;
  logic        ld_mis, st_mis, stall, rvalid;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus_if ();

  mem_lsu #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk                                 (clk),
    .rst                                 (rst),
    .lsu_mem_read                        (mem_read),
    .lsu_mem_write                       (mem_write),
    .lsu_mem_opcode                      (opcode),
    .lsu_address                         (address),
    .lsu_writedata                       (wdata),
    .lsu_flush                           (flush),
    .lsu_hold                            (hold),
    .lsu_exception_load_addr_misaligned  (ld_mis),
    .lsu_exception_store_addr_misaligned (st_mis),
    .lsu_stall_req                       (stall),
    .lsu_readdata                        (rdata),
    .lsu_readdata_valid                  (rvalid),
    .bus                                 (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past a rising edge; inputs change and checks follow in the low-activity window.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    flush     = 1'b0;
    hold      = 1'b0;
    opcode    = 3'b000;
    address   = 32'h0;
    wdata     = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus_if.waitrequest   = 1'b0;
    bus_if.readdata      = 32'h0;
    bus_if.readdatavalid = 1'b0;
    tick(); tick();
    #1;
    chk("rst_read", {31'd0, bus_if.read}, 32'd0);
    chk("rst_write", {31'd0, bus_if.write}, 32'd0);
    chk("rst_be", {28'd0, bus_if.byteenable}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, rvalid}, 32'd0);
    rst = 1'b0;
    tick();

    // SB 0x1003
    mem_write = 1'b1; opcode = 3'b000; address = 32'h1003; wdata = 32'hAABBCCDD;
    #1;
    chk("sb_nofault", {31'd0, st_mis}, 32'd0);
    tick();
    idle_inputs();
    #1;
    $display("[TB] SB 0x1003 write=%0b addr=0x%08h be=%b wd=0x%08h", bus_if.write,
             bus_if.address, bus_if.byteenable, bus_if.writedata);
    chk("sb_write", {31'd0, bus_if.write}, 32'd1);
    chk("sb_addr", bus_if.address, 32'h1000);
    chk("sb_be", {28'd0, bus_if.byteenable}, 32'h8);
    chk("sb_wdata", bus_if.writedata, 32'hDDDDDDDD);
    chk("sb_stall", {31'd0, stall}, 32'd0);
    tick();
    #1;
    chk("sb_done", {31'd0, bus_if.write}, 32'd0);

    // LH 0x2002 with 3 wait cycles and 2 latency cycles
    mem_read = 1'b1; opcode = 3'b001; address = 32'h2002;
    tick();
    idle_inputs();
    bus_if.waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lh_wait_read", {31'd0, bus_if.read}, 32'd1);
      chk("lh_wait_stall", {31'd0, stall}, 32'd1);
      tick();
    end
    bus_if.waitrequest = 1'b0;
    #1;
    chk("lh_cmd_addr", bus_if.address, 32'h2000);
    chk("lh_cmd_be", {28'd0, bus_if.byteenable}, 32'hF);
    chk("lh_cmd_stall", {31'd0, stall}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lh_resp_read", {31'd0, bus_if.read}, 32'd0);
      chk("lh_resp_stall", {31'd0, stall}, 32'd1);
      chk("lh_resp_valid", {31'd0, rvalid}, 32'd0);
      tick();
    end
    bus_if.readdata = 32'h80011234; bus_if.readdatavalid = 1'b1;
    #1;
    $display("[TB] LH 0x2002 rdata=0x%08h valid=%0b", rdata, rvalid);
    chk("lh_data", rdata, 32'hFFFF8001);
    chk("lh_valid", {31'd0, rvalid}, 32'd1);
    chk("lh_done_stall", {31'd0, stall}, 32'd0);
    tick();
    bus_if.readdatavalid = 1'b0;
    #1;
    chk("lh_valid_once", {31'd0, rvalid}, 32'd0);
    chk("lh_rdata_zero", rdata, 32'h0);

    // LHU 0x2002, same data
    mem_read = 1'b1; opcode = 3'b101; address = 32'h2002;
    tick();
    idle_inputs();
    tick();
    bus_if.readdatavalid = 1'b1;
    #1;
    $display("[TB] LHU 0x2002 rdata=0x%08h valid=%0b", rdata, rvalid);
    chk("lhu_data", rdata, 32'h00008001);
    tick();
    bus_if.readdatavalid = 1'b0;

    // LB 0x7001: byte lane 1 sign-extended
    mem_read = 1'b1; opcode = 3'b000; address = 32'h7001;
    tick();
    idle_inputs();
    tick();
    bus_if.readdata = 32'h00008000; bus_if.readdatavalid = 1'b1;
    #1;
    $display("[TB] LB 0x7001 rdata=0x%08h", rdata);
    chk("lb_data", rdata, 32'hFFFFFF80);
    tick();
    bus_if.readdatavalid = 1'b0;

    // Misalignment
    mem_read = 1'b1; opcode = 3'b010; address = 32'h3001;
    #1;
    chk("lw_mis", {31'd0, ld_mis}, 32'd1);
    chk("lw_mis_st", {31'd0, st_mis}, 32'd0);
    flush = 1'b1;
    #1;
    chk("lw_mis_flush", {31'd0, ld_mis}, 32'd0);
    flush = 1'b0;
    tick();
    #1;
    chk("lw_mis_nobus", {31'd0, bus_if.read}, 32'd0);
    chk("lw_mis_nostall", {31'd0, stall}, 32'd0);
    mem_read = 1'b0; mem_write = 1'b1; opcode = 3'b001;
    #1;
    chk("sh_mis", {31'd0, st_mis}, 32'd1);
    chk("sh_mis_ld", {31'd0, ld_mis}, 32'd0);
    opcode = 3'b000;
    #1;
    chk("sb_3001_ok", {31'd0, st_mis}, 32'd0);
    idle_inputs();
    $display("[TB] misalign LW/SH/SB 0x3001 checked");
    tick();

    // Load in flight; younger store flushed in execute
    mem_read = 1'b1; opcode = 3'b010; address = 32'h4000;
    tick();
    idle_inputs();
    mem_write = 1'b1; opcode = 3'b010; address = 32'h5000; wdata = 32'hCAFEF00D; flush = 1'b1;
    #1;
    chk("fl_read", {31'd0, bus_if.read}, 32'd1);
    chk("fl_addr", bus_if.address, 32'h4000);
    tick();
    bus_if.readdata = 32'h12345678; bus_if.readdatavalid = 1'b1;
    #1;
    $display("[TB] flush: load rdata=0x%08h write=%0b", rdata, bus_if.write);
    chk("fl_data", rdata, 32'h12345678);
    chk("fl_nowrite", {31'd0, bus_if.write}, 32'd0);
    tick();
    bus_if.readdatavalid = 1'b0;
    idle_inputs();
    #1;
    chk("fl_after_write", {31'd0, bus_if.write}, 32'd0);
    chk("fl_after_read", {31'd0, bus_if.read}, 32'd0);

    // Back-to-back stores
    mem_write = 1'b1; opcode = 3'b010; address = 32'h6000; wdata = 32'h11111111;
    tick();
    address = 32'h6004; wdata = 32'h22222222;
    #1;
    chk("b2b_w0", {31'd0, bus_if.write}, 32'd1);
    chk("b2b_a0", bus_if.address, 32'h6000);
    chk("b2b_s0", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    $display("[TB] b2b second write=%0b addr=0x%08h wd=0x%08h", bus_if.write, bus_if.address,
             bus_if.writedata);
    chk("b2b_w1", {31'd0, bus_if.write}, 32'd1);
    chk("b2b_a1", bus_if.address, 32'h6004);
    chk("b2b_d1", bus_if.writedata, 32'h22222222);
    chk("b2b_s1", {31'd0, stall}, 32'd0);
    tick();
    #1;
    chk("b2b_end", {31'd0, bus_if.write}, 32'd0);

    // Reset while waiting in RESP
    mem_read = 1'b1; opcode = 3'b010; address = 32'h7000;
    tick();
    idle_inputs();
    tick();
    #1;
    chk("rr_stall_pre", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rr_read", {31'd0, bus_if.read}, 32'd0);
    chk("rr_write", {31'd0, bus_if.write}, 32'd0);
    chk("rr_be", {28'd0, bus_if.byteenable}, 32'd0);
    chk("rr_stall", {31'd0, stall}, 32'd0);
    bus_if.readdata = 32'hDEADBEEF; bus_if.readdatavalid = 1'b1;
    #1;
    $display("[TB] reset in RESP: late valid=%0b rdata=0x%08h", rvalid, rdata);
    chk("rr_late_valid", {31'd0, rvalid}, 32'd0);
    chk("rr_late_data", rdata, 32'h0);
    tick();
    bus_if.readdatavalid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
